serial_bit_feeder: RTL
======================

Name: serial_bit_feeder

Overview:
- Upstream stage of the 4-state Mealy sequence detector: converts parallel words, accepted over a valid/ready handshake, into the one-bit-per-clock stream the detector samples on its data_in.
- Includes one holding register, so back-to-back words stream with no idle bit between them.
- Also produces bit-valid and frame-start qualifiers for the detector's neighbours and for debug.

Parameters:
- WIDTH, 8: word width in bits; legal range 2..32.
- MSB_FIRST, 1: 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- IDLE_LEVEL, 0: value driven on serial_out when no word is being shifted.

Ports:
- clk  input  1  rising-edge clock shared with the detector.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  input  1  producer has a word on in_data.
- in_data  input  WIDTH  word to serialise.
- in_ready  output  1  hold register empty; a transfer occurs when in_valid && in_ready at a rising edge.
- serial_out  output  1  serial bit; drives the detector's data_in.
- bit_valid  output  1  serial_out carries a payload bit this cycle.
- frame_start  output  1  one-cycle pulse coincident with the first bit of each word.
- bit_index  output  $clog2(WIDTH)  position (0..WIDTH-1) of the bit currently on serial_out; 0 when idle.
- busy  output  1  shifter active or hold register full.

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE, hold empty, shifter cleared.
  - serial_out = IDLE_LEVEL; bit_valid = 0; frame_start = 0; bit_index = 0; busy = 0.
  - in_ready = 1 from the first clk edge after reset is released.
- All outputs except in_ready are registered. in_ready = !hold_full, decoded from a register, with no combinational path from in_valid.
- Handshake:
  - An accepted word is always written into the hold register.
  - in_ready deasserts the cycle after acceptance and reasserts the cycle after the hold register is unloaded into the shifter.
  - in_data is ignored whenever in_valid = 0 or in_ready = 0.
- FSM states: IDLE, SHIFT.
  - IDLE → SHIFT at the edge where the hold register is full. The shifter loads from hold, bit_index = 0, frame_start = 1, bit_valid = 1, and serial_out = first bit.
  - SHIFT, bit_index < WIDTH-1: advance one bit per clock, bit_index += 1, frame_start = 0.
  - SHIFT, bit_index = WIDTH-1, hold full: reload the shifter from hold on the next edge and stay in SHIFT (gapless). bit_index → 0, frame_start = 1.
  - SHIFT, bit_index = WIDTH-1, hold empty: go to IDLE. serial_out = IDLE_LEVEL, bit_valid = 0.
- Latency:
  - Word accepted at edge N (idle, hold empty) → hold full after N → first bit on serial_out after edge N+1.
  - Last bit of that word is on serial_out after edge N+WIDTH.
- Simultaneous load and accept: if hold unloads into the shifter at edge M, in_ready is 0 during the cycle before M. A new word can be accepted at edge M+1 at the earliest. That word is still in hold before the current word's last bit (WIDTH ≥ 2), so streaming stays gapless at maximum producer rate.
- in_valid held high with data changing while in_ready = 0: no effect, no data loss, no duplication.
- Reset mid-word:
  - The partial word and the held word are discarded.
  - Outputs go to reset values immediately.
  - No frame_start is generated after release until a new word is accepted.
- Bit order follows MSB_FIRST; the shifter shifts left when MSB_FIRST = 1 and right when MSB_FIRST = 0. bit_index counts transmit order, not word bit position.
- bit_index saturates at no value: it wraps WIDTH-1 → 0 only on reload.

Decomposition:
- Shared package (e.g. feeder_pkg):
  - enum typedef {IDLE, SHIFT} for the state.
  - localparam for the bit_index width, $clog2(WIDTH).
  - Default IDLE_LEVEL constant, so detector benches reuse the same idle value.
- One natural sub-module: feeder_shift_reg, a loadable WIDTH-bit shifter with direction parameter MSB_FIRST that exposes its current output bit. Handshake, hold register, FSM and counter stay in serial_bit_feeder.

Test Plan (WIDTH = 8, MSB_FIRST = 1, IDLE_LEVEL = 0 unless stated):
- Single word: reset, then in_data = 8'hB4 accepted at edge N → serial_out over edges N+1..N+8 = 1,0,1,1,0,1,0,0. bit_valid = 1 for exactly 8 cycles, frame_start only after N+1, then serial_out = 0 and busy = 0.
- Back-to-back: in_valid held high with words 8'hFF, 8'h00, 8'hA5 → 24 consecutive bit_valid cycles with no gap. frame_start pulses at bit_index 0 of each word. Exactly 3 handshakes occur.
- Backpressure: in_valid = 1 while in_ready = 0, with in_data toggling 8'h11/8'h22 every cycle → only the values present at the handshake edges are serialised, each exactly once.
- LSB-first: MSB_FIRST = 0, in_data = 8'h01 → first bit on serial_out = 1, followed by seven 0s.
- Reset mid-word: assert reset after the 3rd bit of 8'hF0, with a second word held → serial_out = IDLE_LEVEL, bit_valid = 0, in_ready = 1 after release. Neither word appears afterwards.
- Detector integration: feed 8'b0110_1110 into the Mealy detector's data_in → the detector state and data_out sequence match the golden model bit-for-bit, with bit_valid aligned to each detector clock.

Source files
------------

// File: rtl/feeder_pkg.sv
// Shared definitions for the serial bit feeder and its neighbours.
//   feeder_state_e       : feeder FSM state (IDLE, SHIFT)
//   FEEDER_DEFAULT_WIDTH : default word width
//   FEEDER_IDX_W         : bit_index width for the default word width
//   FEEDER_IDLE_LEVEL    : line level while no word is shifted; detector
//                          benches reuse it so both agree on the idle value
//   feeder_idx_width()   : bit_index width for an arbitrary word width
package feeder_pkg;

   typedef enum logic {
      IDLE,
      SHIFT
   } feeder_state_e;

   localparam int unsigned FEEDER_DEFAULT_WIDTH = 8;
   localparam int unsigned FEEDER_IDX_W         = $clog2(FEEDER_DEFAULT_WIDTH);
   localparam logic        FEEDER_IDLE_LEVEL    = 1'b0;

   function automatic int unsigned feeder_idx_width(input int unsigned width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/feeder_shift_reg.sv
// Loadable WIDTH-bit shifter.
//   clk, reset : clock, asynchronous active-low reset (clears to FILL)
//   load       : capture load_data (has priority over shift)
//   shift      : move one bit toward the output end, shifting FILL in
//   load_data  : parallel word
//   out_bit    : bit currently at the output end (MSB when MSB_FIRST=1)
module feeder_shift_reg #(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1,
   parameter logic        FILL      = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] load_data,
   output logic             out_bit
);

   logic [WIDTH-1:0] q;

   // Shifting in FILL means that after WIDTH shifts the register holds only
   // FILL, so the output end is already at the idle level when a word ends.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q <= {WIDTH{FILL}};
      end else if (load) begin
         q <= load_data;
      end else if (shift) begin
         if (MSB_FIRST) q <= {q[WIDTH-2:0], FILL};
         else           q <= {FILL, q[WIDTH-1:1]};
      end
   end

   assign out_bit = MSB_FIRST ? q[WIDTH-1] : q[0];

endmodule

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder for the Mealy sequence detector.
//   clk, reset  : clock, asynchronous active-low reset
//   in_valid    : producer has a word on in_data
//   in_data     : word to serialise (WIDTH bits)
//   in_ready    : hold register empty; transfer on in_valid && in_ready
//   serial_out  : serial bit (IDLE_LEVEL when idle)
//   bit_valid   : serial_out carries a payload bit
//   frame_start : pulse with the first bit of each word
//   bit_index   : transmit position of the bit on serial_out, 0 when idle
//   busy        : shifter active or hold register full
module serial_bit_feeder
   import feeder_pkg::*;
#(
   parameter int unsigned WIDTH      = FEEDER_DEFAULT_WIDTH,
   parameter bit          MSB_FIRST  = 1'b1,
   parameter logic        IDLE_LEVEL = FEEDER_IDLE_LEVEL
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic [WIDTH-1:0]         in_data,
   output logic                     in_ready,
   output logic                     serial_out,
   output logic                     bit_valid,
   output logic                     frame_start,
   output logic [$clog2(WIDTH)-1:0] bit_index,
   output logic                     busy
);

   localparam int unsigned   IW   = feeder_idx_width(WIDTH);
   localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

   feeder_state_e    state, state_d;
   logic             hold_full, hold_full_d;
   logic [WIDTH-1:0] hold_data;
   logic             ready_en;
   logic [IW-1:0]    count, count_d;
   logic             bit_valid_d, frame_start_d, busy_d;
   logic             accept, unload, last_bit, shift_en;

   assign accept   = in_valid && in_ready;
   assign last_bit = (state == SHIFT) && (count == LAST);
   // Hold drains into the shifter when idle or as the last bit leaves.
   assign unload   = hold_full && ((state == IDLE) || last_bit);
   assign shift_en = (state == SHIFT) && !unload;

   // ready_en keeps in_ready low until the first edge after reset release.
   assign in_ready = ready_en && !hold_full;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state;
      unique case (state)
         IDLE:    if (hold_full)              state_d = SHIFT;
         SHIFT:   if (last_bit && !hold_full) state_d = IDLE;
         default:                             state_d = IDLE;
      endcase
   end

   // Next values of the registered outputs and the handshake state
   always_comb begin
      hold_full_d = hold_full;
      if (accept)      hold_full_d = 1'b1;
      else if (unload) hold_full_d = 1'b0;

      count_d = '0;
      if ((state == SHIFT) && !last_bit) count_d = count + 1'b1;

      bit_valid_d   = (state_d == SHIFT);
      frame_start_d = unload;
      busy_d        = (state_d == SHIFT) || hold_full_d;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hold_full   <= 1'b0;
         hold_data   <= '0;
         ready_en    <= 1'b0;
         count       <= '0;
         bit_valid   <= 1'b0;
         frame_start <= 1'b0;
         busy        <= 1'b0;
      end else begin
         hold_full   <= hold_full_d;
         ready_en    <= 1'b1;
         count       <= count_d;
         bit_valid   <= bit_valid_d;
         frame_start <= frame_start_d;
         busy        <= busy_d;
         if (accept) hold_data <= in_data;
      end
   end

   assign bit_index = count;

   feeder_shift_reg #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST),
      .FILL      (IDLE_LEVEL)
   ) u_shift (
      .clk       (clk),
      .reset     (reset),
      .load      (unload),
      .shift     (shift_en),
      .load_data (hold_data),
      .out_bit   (serial_out)
   );

endmodule
